// File: rtl/timekeeper_if.sv
// Control and time bus of the timekeeper core: count/load/alarm controls
// driven by the clock top level, registered time and pulses back from the core.
interface timekeeper_if #(
  parameter int CLK_HZ = 100_000_000
);
  localparam int CNT_W = $clog2(CLK_HZ);

  // load is a single-cycle request with no ready: it is sampled on the edge
  // where it is high and answered on that same edge, either by taking the
  // load_* values or by a one-cycle load_err pulse; it must not be held high.
  logic             en;
  logic             mode_12h;
  logic             load;
  logic [4:0]       load_hour;
  logic [5:0]       load_minute;
  logic [5:0]       load_second;
  logic             alarm_en;
  logic [4:0]       alarm_hour;
  logic [5:0]       alarm_minute;

  logic [5:0]       second;
  logic [5:0]       minute;
  logic [4:0]       hour;
  logic [4:0]       disp_hour;
  logic             pm;
  logic [CNT_W-1:0] sec_count;
  logic             sec_tick;
  logic             day_tick;
  logic             alarm;
  logic             load_err;

  modport master (
    output en, mode_12h, load, load_hour, load_minute, load_second,
           alarm_en, alarm_hour, alarm_minute,
    input  second, minute, hour, disp_hour, pm, sec_count,
           sec_tick, day_tick, alarm, load_err
  );

  modport slave (
    input  en, mode_12h, load, load_hour, load_minute, load_second,
           alarm_en, alarm_hour, alarm_minute,
    output second, minute, hour, disp_hour, pm, sec_count,
           sec_tick, day_tick, alarm, load_err
  );
endinterface

// File: rtl/timekeeper.sv
// Real-time clock core: prescales clk to a 1 Hz tick and keeps hh:mm:ss with
// validated load, 12/24-hour display and a single daily alarm.
module timekeeper #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic          clk,
  input  logic          reset_n,
  timekeeper_if.slave   bus
);
  localparam int CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] TC = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] sec_count_q;
  logic [5:0]       second_q;
  logic [5:0]       minute_q;
  logic [4:0]       hour_q;
  logic             sec_tick_q;
  logic             day_tick_q;
  logic             alarm_q;
  logic             load_err_q;

  logic             terminal;
  logic             load_ok;
  logic [5:0]       second_inc;
  logic [5:0]       minute_inc;
  logic [4:0]       hour_inc;
  logic             day_wrap;
  logic             alarm_hit;

  assign terminal = bus.en && (sec_count_q == TC);
  assign load_ok  = bus.load && (bus.load_hour < 5'd24) &&
                    (bus.load_minute < 6'd60) && (bus.load_second < 6'd60);

  // Time one second ahead of the current value, with carries.
  always_comb begin
    second_inc = second_q + 6'd1;
    minute_inc = minute_q;
    hour_inc   = hour_q;
    day_wrap   = 1'b0;
    if (second_q == 6'd59) begin
      second_inc = 6'd0;
      minute_inc = minute_q + 6'd1;
      if (minute_q == 6'd59) begin
        minute_inc = 6'd0;
        hour_inc   = hour_q + 5'd1;
        if (hour_q == 5'd23) begin
          hour_inc = 5'd0;
          day_wrap = 1'b1;
        end
      end
    end
  end

  // hour_inc never exceeds 23 and minute_inc never exceeds 59, so an
  // out-of-range alarm time can never compare equal.
  assign alarm_hit = bus.alarm_en && (second_inc == 6'd0) &&
                     (minute_inc == bus.alarm_minute) &&
                     (hour_inc == bus.alarm_hour);

  always_ff @(posedge clk) begin
    if (reset_n) begin
      sec_count_q <= '0;
      second_q    <= '0;
      minute_q    <= '0;
      hour_q      <= '0;
      sec_tick_q  <= 1'b0;
      day_tick_q  <= 1'b0;
      alarm_q     <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= bus.load && !load_ok;
      if (load_ok) begin
        sec_count_q <= '0;
        second_q    <= bus.load_second;
        minute_q    <= bus.load_minute;
        hour_q      <= bus.load_hour;
      end else if (terminal) begin
        sec_count_q <= '0;
        second_q    <= second_inc;
        minute_q    <= minute_inc;
        hour_q      <= hour_inc;
        sec_tick_q  <= 1'b1;
        day_tick_q  <= day_wrap;
        alarm_q     <= alarm_hit;
      end else if (bus.en) begin
        sec_count_q <= sec_count_q + 1'b1;
      end
    end
  end

  // Display conversion only; the stored hour is always 24-hour.
  always_comb begin
    bus.disp_hour = hour_q;
    bus.pm        = 1'b0;
    if (bus.mode_12h) begin
      if (hour_q == 5'd0) begin
        bus.disp_hour = 5'd12;
      end else if (hour_q == 5'd12) begin
        bus.pm = 1'b1;
      end else if (hour_q > 5'd12) begin
        bus.disp_hour = hour_q - 5'd12;
        bus.pm        = 1'b1;
      end
    end
  end

  assign bus.sec_count = sec_count_q;
  assign bus.second    = second_q;
  assign bus.minute    = minute_q;
  assign bus.hour      = hour_q;
  assign bus.sec_tick  = sec_tick_q;
  assign bus.day_tick  = day_tick_q;
  assign bus.alarm     = alarm_q;
  assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_timekeeper.sv
// Directed bench for timekeeper at CLK_HZ=10: prescaler latency, rollover,
// load validation, alarm, display modes, enable freeze and reset.
module tb_timekeeper;
  localparam int CLK_HZ = 10;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fails;

  timekeeper_if #(.CLK_HZ(CLK_HZ)) bus ();

  timekeeper #(.CLK_HZ(CLK_HZ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int h, input int m, input int s);
    bus.load        = 1'b1;
    bus.load_hour   = 5'(h);
    bus.load_minute = 6'(m);
    bus.load_second = 6'(s);
    step(1);
    bus.load = 1'b0;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hour"},   int'(bus.hour),   h);
    check({tag, "_minute"}, int'(bus.minute), m);
    check({tag, "_second"}, int'(bus.second), s);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset_n  = 1'b1;
    bus.en = 1'b0; bus.mode_12h = 1'b0; bus.load = 1'b0;
    bus.load_hour = '0; bus.load_minute = '0; bus.load_second = '0;
    bus.alarm_en = 1'b0; bus.alarm_hour = '0; bus.alarm_minute = '0;

    // reset state
    step(3);
    check("rst_count", int'(bus.sec_count), 0);
    check_time("rst", 0, 0, 0);
    check("rst_tick", int'(bus.sec_tick), 0);
    check("rst_err", int'(bus.load_err), 0);
    reset_n = 1'b0;
    bus.en  = 1'b1;

    // first tick on the 10th edge after release
    step(9);
    check("pre_count", int'(bus.sec_count), 9);
    check("pre_tick", int'(bus.sec_tick), 0);
    check("pre_second", int'(bus.second), 0);
    step(1);
    check("tick1_second", int'(bus.second), 1);
    check("tick1_tick", int'(bus.sec_tick), 1);
    check("tick1_count", int'(bus.sec_count), 0);
    step(1);
    check("post_tick", int'(bus.sec_tick), 0);
    check("post_count", int'(bus.sec_count), 1);
    step(9);
    check("tick2_second", int'(bus.second), 2);
    check("tick2_tick", int'(bus.sec_tick), 1);

    // day rollover
    do_load(23, 59, 59);
    check_time("ld_max", 23, 59, 59);
    check("ld_max_count", int'(bus.sec_count), 0);
    check("ld_max_tick", int'(bus.sec_tick), 0);
    check("ld_max_err", int'(bus.load_err), 0);
    step(9);
    check("roll_pre_day", int'(bus.day_tick), 0);
    step(1);
    check_time("roll", 0, 0, 0);
    check("roll_tick", int'(bus.sec_tick), 1);
    check("roll_day", int'(bus.day_tick), 1);
    check("roll_err", int'(bus.load_err), 0);
    step(1);
    check("roll_day_end", int'(bus.day_tick), 0);

    // rejected loads keep time, prescaler keeps counting (count now 1)
    do_load(24, 0, 0);
    check("bad_h_err", int'(bus.load_err), 1);
    check_time("bad_h", 0, 0, 0);
    check("bad_h_count", int'(bus.sec_count), 2);
    do_load(12, 60, 0);
    check("bad_m_err", int'(bus.load_err), 1);
    check_time("bad_m", 0, 0, 0);
    check("bad_m_count", int'(bus.sec_count), 3);
    step(1);
    check("bad_err_end", int'(bus.load_err), 0);
    check("bad_end_count", int'(bus.sec_count), 4);

    // alarm by tick, not by load
    bus.alarm_en = 1'b1; bus.alarm_hour = 5'd7; bus.alarm_minute = 6'd30;
    do_load(7, 29, 59);
    check("al_ld_alarm", int'(bus.alarm), 0);
    step(9);
    check("al_pre_alarm", int'(bus.alarm), 0);
    step(1);
    check_time("al_hit", 7, 30, 0);
    check("al_hit_alarm", int'(bus.alarm), 1);
    check("al_hit_tick", int'(bus.sec_tick), 1);
    step(1);
    check("al_once", int'(bus.alarm), 0);
    do_load(7, 30, 0);
    check("al_load_alarm", int'(bus.alarm), 0);
    step(10);
    check("al_next_alarm", int'(bus.alarm), 0);
    check("al_next_second", int'(bus.second), 1);
    bus.alarm_en = 1'b0;

    // 12-hour display
    bus.mode_12h = 1'b1;
    do_load(0, 0, 0);
    check("d0_hour", int'(bus.disp_hour), 12);
    check("d0_pm", int'(bus.pm), 0);
    do_load(11, 0, 0);
    check("d11_hour", int'(bus.disp_hour), 11);
    check("d11_pm", int'(bus.pm), 0);
    do_load(12, 0, 0);
    check("d12_hour", int'(bus.disp_hour), 12);
    check("d12_pm", int'(bus.pm), 1);
    do_load(13, 0, 0);
    check("d13_hour", int'(bus.disp_hour), 1);
    check("d13_pm", int'(bus.pm), 1);
    bus.mode_12h = 1'b0;
    #1;
    check("d24_hour", int'(bus.disp_hour), 13);
    check("d24_pm", int'(bus.pm), 0);
    check("d24_stored", int'(bus.hour), 13);

    // enable low for 7 cycles delays the tick by 7
    step(4);
    check("en_count", int'(bus.sec_count), 4);
    bus.en = 1'b0;
    step(7);
    check("frz_count", int'(bus.sec_count), 4);
    check("frz_tick", int'(bus.sec_tick), 0);
    check("frz_second", int'(bus.second), 0);
    bus.en = 1'b1;
    step(5);
    check("res_count", int'(bus.sec_count), 9);
    check("res_second", int'(bus.second), 0);
    step(1);
    check("res_tick", int'(bus.sec_tick), 1);
    check("res_second1", int'(bus.second), 1);

    // valid load at terminal count: tick lost
    step(9);
    check("tc_count", int'(bus.sec_count), 9);
    do_load(5, 6, 7);
    check("tc_ld_tick", int'(bus.sec_tick), 0);
    check_time("tc_ld", 5, 6, 7);
    check("tc_ld_count", int'(bus.sec_count), 0);
    step(10);
    check("tc_next_second", int'(bus.second), 8);
    check("tc_next_tick", int'(bus.sec_tick), 1);

    // invalid load at terminal count: tick still happens
    step(9);
    do_load(31, 0, 0);
    check("tcbad_err", int'(bus.load_err), 1);
    check("tcbad_tick", int'(bus.sec_tick), 1);
    check_time("tcbad", 5, 6, 9);

    // reset mid-count
    step(4);
    check("mid_count", int'(bus.sec_count), 4);
    reset_n = 1'b1;
    step(1);
    check("mrst_count", int'(bus.sec_count), 0);
    check_time("mrst", 0, 0, 0);
    check("mrst_tick", int'(bus.sec_tick), 0);
    reset_n = 1'b0;
    step(9);
    check("mrst_pre_tick", int'(bus.sec_tick), 0);
    check("mrst_pre_second", int'(bus.second), 0);
    step(1);
    check("mrst_tick1", int'(bus.sec_tick), 1);
    check("mrst_second1", int'(bus.second), 1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/timekeeper.md
# timekeeper

Parametrised real-time clock core that supersedes the fixed-rate clock block. It divides `clk` down to a 1 Hz tick with a configurable prescaler and keeps a 24-hour hh:mm:ss count. It adds count enable, validated synchronous time load, a 12/24-hour display mode and a single daily alarm. The core feeds the display and alarm logic of the clock top level.

## Interface
- `CLK_HZ`, default 100_000_000: input clock cycles per second; must be ≥ 2.
- `CNT_W`, default `$clog2(CLK_HZ)`: prescaler width (localparam, derived).
- `clk`  in  1: system clock; all logic on the rising edge.
- `reset_n`  in  1: synchronous, active-high reset. The name is kept from the existing clock block for drop-in compatibility; polarity is high.
- `en`  in  1: count enable; when low, the prescaler and time registers hold.
- `mode_12h`  in  1: selects 12-hour display format for `disp_hour`/`pm`.
- `load`  in  1: one-cycle request to load the time from `load_*`.
- `load_hour` in 5, `load_minute` in 6, `load_second` in 6: time to load.
- `alarm_en`  in  1: arms the alarm compare.
- `alarm_hour` in 5, `alarm_minute` in 6: alarm time, always in 24-hour format.
- `second` out 6, `minute` out 6, `hour` out 5: registered time; `hour` is 0–23.
- `disp_hour` out 5, `pm` out 1: display hour and PM flag, combinational from `hour`.
- `sec_count` out CNT_W: prescaler value, 0..CLK_HZ-1.
- `sec_tick` out 1: one-cycle pulse when the seconds advance.
- `day_tick` out 1: one-cycle pulse on the 23:59:59 → 00:00:00 rollover.
- `alarm` out 1: one-cycle alarm pulse.
- `load_err` out 1: one-cycle pulse when a load request is rejected.

## Operation
- Reset (`reset_n`=1 at an edge): `sec_count`, `second`, `minute` and `hour` all go to 0. `sec_tick`, `day_tick`, `alarm` and `load_err` go to 0. Reset overrides every other input.
- Prescaler, with `en`=1 and no load:
  - If `sec_count` < CLK_HZ-1, it increments.
  - If `sec_count` = CLK_HZ-1, it goes to 0, the time advances by one second and `sec_tick`=1 for that cycle.
- Time advance:
  - `second` 59→0 carries into `minute`.
  - `minute` 59→0 carries into `hour`.
  - `hour` 23→0 raises `day_tick` in the same cycle as `sec_tick`.
  - The time registers never hold values outside 0–59 (sec/min) or 0–23 (hour).
- `en`=0: `sec_count` and the time registers hold and no ticks are generated. Load still works.
- Load:
  - Valid load (`load`=1 with `load_hour`<24, `load_minute`<60 and `load_second`<60): at that edge the time takes the load values and `sec_count` goes to 0. Ticks are suppressed that cycle and `load_err`=0.
  - Invalid load: the time and prescaler behave as if `load`=0, including a normal tick if one is due, and `load_err`=1 for one cycle.
  - A valid load wins over a simultaneous prescaler terminal count; that tick is lost.
- Alarm:
  - `alarm`=1 for exactly one cycle when a tick (not a load) moves the time to `alarm_hour`:`alarm_minute`:00 while `alarm_en`=1. It coincides with that `sec_tick`.
  - Loading a time equal to the alarm time does not fire the alarm.
  - An out-of-range alarm time never matches.
- Display, with `mode_12h`=1:
  - `hour`=0 gives `disp_hour`=12, `pm`=0.
  - `hour` 1–11 gives `disp_hour`=`hour`, `pm`=0.
  - `hour`=12 gives `disp_hour`=12, `pm`=1.
  - `hour` 13–23 gives `disp_hour`=`hour`-12, `pm`=1.
- Display, with `mode_12h`=0: `disp_hour`=`hour`, `pm`=0. Changing the mode never affects the stored time.

## Timing
- All outputs except `disp_hour`/`pm` are registered. The pulse outputs are high for exactly one cycle, aligned with the edge at which the time registers take their new value.
- Latency from reset release with `en` held at 1: `second` becomes 1 and `sec_tick` pulses on the CLK_HZ-th edge after reset deasserts, then every CLK_HZ edges after that.
- Load latency is one edge: the new time is visible in the cycle after `load` is sampled, and the next tick follows CLK_HZ enabled edges later.
- Deasserting `en` freezes the count exactly. Re-enabling resumes from the held `sec_count`, so the seconds period excludes the disabled cycles.
- Reset asserted in the middle of a second discards the partial count; no tick is produced at or after that reset edge until CLK_HZ enabled edges have elapsed.

## Test plan
- CLK_HZ=10, reset for 3 cycles, then `en`=1 → `second`=1 and `sec_tick` pulse on the 10th edge after release, `sec_count` back at 0; `second`=2 on the 20th.
- Load 23:59:59, run 10 cycles → 00:00:00 with `sec_tick`, `day_tick` and no `load_err`.
- Load 24:00:00, then load 12:60:00 → `load_err` pulses each time, the time is unchanged and the prescaler keeps counting.
- Alarm 07:30 armed, load 07:29:59, run 10 cycles → `alarm` pulses once at 07:30:00. Loading 07:30:00 directly → no `alarm`.
- `mode_12h`=1 with hour loaded 0, 12, 13 → `disp_hour`/`pm` = 12/0, 12/1, 1/1.
- `en` low for 7 cycles mid-second → the tick is delayed by exactly 7 cycles. Valid `load` on the terminal-count cycle → load takes effect, no tick. Reset mid-count → all outputs return to 0.
